// File: rtl/stream_demux8_pkg.sv
// Shared constants and helpers for the 1-to-8 stream demultiplexer.
package stream_demux8_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  // Bit offset of channel k inside a flattened NCH*w payload bus.
  function automatic int chan_slice(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice: holds a single beat for one output channel.
// A drain and a load in the same cycle reload the slot, so a ready
// consumer sees one beat per cycle.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              can_load
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Slot occupancy and payload next-state; data only changes on a load.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = data_in;
    end else if (full_q && ready_in) begin
      full_d = 1'b0;
    end
  end

  // State register; payload clears on reset so outputs start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign valid_out = full_q;
  assign data_out  = data_q;
  assign can_load  = !full_q || ready_in;

endmodule

// File: rtl/stream_demux8.sv
// Registered 1-to-8 stream demultiplexer. Each channel owns a one-entry
// slot so a stalled consumer only blocks beats addressed to it.
// Optional broadcast input enabled by defining STREAM_DEMUX8_BCAST_EN.
module stream_demux8
  import stream_demux8_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [NCH-1:0]        out_valid,
`ifdef STREAM_DEMUX8_BCAST_EN
  input  logic [NCH-1:0]        out_ready,
  input  logic                  in_bcast
`else
  input  logic [NCH-1:0]        out_ready
`endif
);

  logic [NCH-1:0] can_load;
  logic [NCH-1:0] load;
  logic           bcast;
  logic           accept;

`ifdef STREAM_DEMUX8_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Ready looks only at the addressed slot, or at every slot for a broadcast
  // so that a broadcast is never partially delivered.
  always_comb begin
    in_ready = can_load[in_sel];
    if (bcast) begin
      in_ready = &can_load;
    end
  end

  assign accept = in_valid && in_ready;

  // Select decode: one-hot load for unicast, all slots for broadcast.
  always_comb begin
    load = '0;
    if (accept) begin
      if (bcast) begin
        load = '1;
      end else begin
        load[in_sel] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .data_in   (in_data),
      .valid_out (out_valid[k]),
      .ready_in  (out_ready[k]),
      .data_out  (out_data[chan_slice(k, DATA_W) +: DATA_W]),
      .can_load  (can_load[k])
    );
  end

endmodule

// File: doc/stream_demux8.md
Name: stream_demux8

Overview:
- Registered 1-to-8 stream demultiplexer. It is the distribution counterpart of the team's 8:1 select mux.
- Accepts one valid/ready input stream with a 3-bit destination select.
- Delivers each beat to one of 8 output channels, each channel buffered by a one-entry register slot.
- Sits between a shared producer (bus bridge, DMA) and 8 independent consumers, so that a stall on one channel blocks only beats routed to that channel.

Parameters:
- width, 8, data width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  width  input beat payload.
- in_sel  input  3  destination channel 0..7; sampled with in_data.
- in_valid  input  1  input beat present.
- in_ready  output  1  demux can accept the beat on in_sel this cycle.
- out_data  output  8*width  channel k payload at bits [k*width +: width].
- out_valid  output  8  per-channel valid, bit k = channel k.
- out_ready  input  8  per-channel consumer ready.

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 8'h00.
  - out_data = all zeros.
  - All slots empty.
  - in_ready = 1 after reset releases.
- Slot k states:
  - EMPTY -> FULL on accept with in_sel==k.
  - FULL -> EMPTY on out_valid[k]&&out_ready[k] with no simultaneous load.
  - FULL -> FULL (reload) when drain and load coincide.
- in_ready = !full[in_sel] || out_ready[in_sel], combinational.
  - in_ready depends only on the addressed slot.
  - in_ready must not depend on in_valid.
- Accept = in_valid && in_ready. On accept, slot[in_sel] loads in_data; out_valid[in_sel] rises next cycle.
- Latency: exactly 1 cycle from accept to out_valid. No combinational path from in_data to out_data.
- Drain of slot k (out_valid[k]&&out_ready[k]):
  - Clears the slot unless reloaded the same cycle.
  - out_data[k] holds its last value after drain; consumers must qualify it with out_valid.
- Full-slot back-pressure: slot full and out_ready[k]=0 -> in_ready=0 for sel k. Beats for other channels still pass.
- Simultaneous events:
  - Full slot draining and loading in the same cycle: new data appears next cycle, out_valid stays 1 (full throughput, one beat/cycle/channel).
  - Drains on multiple channels in one cycle are independent.
- Holding rules:
  - While out_valid[k]=1 and out_ready[k]=0, out_data[k] is stable.
  - in_sel/in_data may change freely while in_valid=0.
- Reset mid-operation: all slots discarded, no beat emitted after reset release.
- Throughput: one accepted beat per cycle sustained when destination consumers are ready.

Optional Feature:
- Macro STREAM_DEMUX8_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - A beat with in_bcast=1 is accepted only when all 8 slots can accept: in_ready = AND over k of (!full[k] || out_ready[k]).
  - On accept, all 8 slots load in_data and in_sel is ignored.
  - Broadcast is atomic: never partially delivered.
- Undefined: port absent, pure unicast routing.

Decomposition:
- Package stream_demux8_pkg:
  - NCH = 8.
  - SEL_W = 3.
  - Function chan_slice(k) returning the bit offset k*width.
- Sub-module demux_slot (one-entry register slice).
  - Ports: clk, rst_n, load, data_in, valid_out, ready_in, data_out, can_load.
  - Instantiated 8 times via generate.
- Top contains only select decode, in_ready mux and the broadcast AND.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=8'h00, out_data=0. Release -> in_ready=1.
- Unicast latency: in_sel=5, in_data=8'hA5, accept at cycle N, out_ready=8'hFF -> out_valid=8'h20 and out_data[47:40]=8'hA5 at N+1 only.
- Isolation:
  - out_ready[2]=0. Send 8'h11 to ch2 -> ch2 holds 8'h11.
  - Second beat to ch2 -> in_ready=0.
  - Beat 8'h22 to ch3 -> accepted, appears on ch3 next cycle.
- Back-to-back reload: ch0 full with 8'h01, out_ready[0]=1, stream 8'h02,8'h03,8'h04 to ch0 every cycle -> in_ready stays 1, out_valid[0] continuously 1, data sequence 01,02,03,04.
- Round-robin: in_sel 0..7 on consecutive cycles with all ready -> each channel asserts out_valid for exactly one cycle, staggered by 1, data intact.
- Broadcast (STREAM_DEMUX8_BCAST_EN):
  - ch6 full and stalled, in_bcast=1 -> in_ready=0, no slot loads.
  - Release out_ready[6] -> beat 8'h5A accepted, out_valid=8'hFF next cycle with 8'h5A on all channels.
